// File: rtl/vga_timing_pattern_gen_if.sv
// Pixel-side bundle between the timing/pattern generator and its video sink.
// The generator drives timing and colour and receives the pattern select.
interface vga_timing_pattern_gen_if #(
   parameter int C_bits  = 12,
   parameter int C_depth = 3
);
   logic [1:0]         pattern;
   logic [C_bits-1:0]  x;
   logic [C_bits-1:0]  y;
   logic [C_depth-1:0] red;
   logic [C_depth-1:0] green;
   logic [C_depth-1:0] blue;
   logic               hsync;
   logic               vsync;
   logic               blank;
   logic               frame_start;
   logic [7:0]         frame;

   modport master (
      input  pattern,
      output x, y, red, green, blue, hsync, vsync, blank, frame_start, frame
   );

   modport slave (
      output pattern,
      input  x, y, red, green, blue, hsync, vsync, blank, frame_start, frame
   );
endinterface

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator with a runtime-selectable test pattern.
// Counters form stage 0; every output is a registered, mutually aligned stage 1.
module vga_timing_pattern_gen #(
   parameter int C_bits   = 12,
   parameter int C_depth  = 3,
   parameter int C_res_x  = 640,
   parameter int C_h_fp   = 16,
   parameter int C_h_sync = 96,
   parameter int C_h_bp   = 48,
   parameter int C_h_pol  = 0,
   parameter int C_res_y  = 480,
   parameter int C_v_fp   = 10,
   parameter int C_v_sync = 2,
   parameter int C_v_bp   = 33,
   parameter int C_v_pol  = 0
) (
   input logic                      clk_pixel,
   input logic                      reset,
   vga_timing_pattern_gen_if.master vga
);
   localparam int H_TOTAL = C_res_x + C_h_fp + C_h_sync + C_h_bp;
   localparam int V_TOTAL = C_res_y + C_v_fp + C_v_sync + C_v_bp;

   localparam logic [C_bits-1:0] RES_X    = C_bits'(C_res_x);
   localparam logic [C_bits-1:0] RES_Y    = C_bits'(C_res_y);
   localparam logic [C_bits-1:0] HS_START = C_bits'(C_res_x + C_h_fp);
   localparam logic [C_bits-1:0] HS_END   = C_bits'(C_res_x + C_h_fp + C_h_sync);
   localparam logic [C_bits-1:0] VS_START = C_bits'(C_res_y + C_v_fp);
   localparam logic [C_bits-1:0] VS_END   = C_bits'(C_res_y + C_v_fp + C_v_sync);
   localparam logic [C_bits-1:0] H_LAST   = C_bits'(H_TOTAL - 1);
   localparam logic [C_bits-1:0] V_LAST   = C_bits'(V_TOTAL - 1);
   localparam logic [C_bits-1:0] BAR_LAST = C_bits'(C_res_x / 8 - 1);
   localparam logic              H_ACT    = 1'(C_h_pol);
   localparam logic              V_ACT    = 1'(C_v_pol);
   localparam logic [C_depth-1:0] FULL    = '1;

   // Stage 0 state: raster counters, bar counter, frame counter, latched pattern
   logic [C_bits-1:0]  hc_q, hc_d, vc_q, vc_d;
   logic [C_bits-1:0]  bcnt_q, bcnt_d;
   logic [2:0]         bar_q, bar_d;
   logic [7:0]         frame_q, frame_d;
   logic [1:0]         pat_q, pat_d;

   // Stage 1 output registers
   logic [C_bits-1:0]  x_q, y_q;
   logic [C_depth-1:0] red_q, green_q, blue_q;
   logic               hsync_q, vsync_q, blank_q, fstart_q;
   logic [7:0]         frame_out_q;

   logic               boundary, visible, hs_act, vs_act;
   logic [C_depth-1:0] red_d, green_d, blue_d;

   always_comb begin
      hc_d     = hc_q + C_bits'(1);
      vc_d     = vc_q;
      bcnt_d   = bcnt_q;
      bar_d    = bar_q;
      boundary = (hc_q == H_LAST) && (vc_q == V_LAST);
      if (hc_q == H_LAST) begin
         hc_d   = '0;
         vc_d   = (vc_q == V_LAST) ? '0 : vc_q + C_bits'(1);
         bcnt_d = '0;
         bar_d  = '0;
      end else if (hc_q < RES_X) begin
         if (bcnt_q == BAR_LAST) begin
            bcnt_d = '0;
            bar_d  = bar_q + 3'd1;
         end else begin
            bcnt_d = bcnt_q + C_bits'(1);
         end
      end
      frame_d = boundary ? frame_q + 8'd1 : frame_q;
      pat_d   = boundary ? vga.pattern : pat_q;
   end

   always_comb begin
      visible = (hc_q < RES_X) && (vc_q < RES_Y);
      hs_act  = (hc_q >= HS_START) && (hc_q < HS_END);
      vs_act  = (vc_q >= VS_START) && (vc_q < VS_END);
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (visible) begin
         case (pat_q)
            2'd0: begin
               red_d   = bar_q[2] ? FULL : '0;
               green_d = bar_q[1] ? FULL : '0;
               blue_d  = bar_q[0] ? FULL : '0;
            end
            2'd1: begin
               if (hc_q[3:0] == 4'd0 || vc_q[3:0] == 4'd0) begin
                  red_d   = FULL;
                  green_d = FULL;
                  blue_d  = FULL;
               end
            end
            2'd2: begin
               red_d   = hc_q[C_depth+2:3];
               green_d = vc_q[C_depth+2:3];
               blue_d  = frame_q[C_depth-1:0];
            end
            default: begin
               if (hc_q[5] ^ vc_q[5] ^ frame_q[4]) begin
                  red_d   = FULL;
                  green_d = FULL;
                  blue_d  = FULL;
               end
            end
         endcase
      end
   end

   // Reset clears both stages together, so a mid-frame reset aborts at once
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         hc_q        <= '0;
         vc_q        <= '0;
         bcnt_q      <= '0;
         bar_q       <= '0;
         frame_q     <= '0;
         pat_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
         hsync_q     <= ~H_ACT;
         vsync_q     <= ~V_ACT;
         blank_q     <= 1'b1;
         fstart_q    <= 1'b0;
         frame_out_q <= '0;
      end else begin
         hc_q        <= hc_d;
         vc_q        <= vc_d;
         bcnt_q      <= bcnt_d;
         bar_q       <= bar_d;
         frame_q     <= frame_d;
         pat_q       <= pat_d;
         x_q         <= hc_q;
         y_q         <= vc_q;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         hsync_q     <= hs_act ? H_ACT : ~H_ACT;
         vsync_q     <= vs_act ? V_ACT : ~V_ACT;
         blank_q     <= ~visible;
         fstart_q    <= (hc_q == '0) && (vc_q == '0);
         frame_out_q <= frame_q;
      end
   end

   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.red         = red_q;
   assign vga.green       = green_q;
   assign vga.blue        = blue_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.blank       = blank_q;
   assign vga.frame_start = fstart_q;
   assign vga.frame       = frame_out_q;
endmodule
